// File: rtl/memory_cycle_pkg.sv
// Package riscv_pkg: constants and types shared by the memory stage.
//   - RV32I load/store funct3 encodings (F3_*)
//   - ResultSrc encodings (RS_*)
//   - mw_reg_t: the fields held in the M->W pipeline register
//   - extend_load(): picks the addressed lanes and sign/zero-extends them
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] read_data;
    logic        misalign;
  } mw_reg_t;

  // Returns 0 for any funct3 that is not a legal load encoding.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (f3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_W:    result = word;
      F3_BU:   result = {24'h0, byte_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: groups the execute->memory inputs and the memory->writeback
// outputs of the memory stage.
//   master: upstream/writeback side (drives *M, observes *W)
//   slave : the memory stage itself (observes *M, drives *W)
interface memory_cycle_if;

  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW;
  logic [31:0] PCPlus4W;
  logic [31:0] ReadDataW;
  logic        MisalignW;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, funct3M, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M,
    input  RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W,
           ReadDataW, MisalignW
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, funct3M, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M,
    output RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W,
           ReadDataW, MisalignW
  );

endinterface

// File: rtl/memory_cycle_dmem.sv
// data_memory_be: DMEM_WORDS x 32-bit data memory.
//   clk      in  clock, writes on the rising edge
//   we_i     in  per-byte write enables (bit i -> bits 8i+7:8i)
//   addr_i   in  word index
//   wdata_i  in  write data, already lane-aligned
//   rdata_o  out asynchronous read of the addressed word
// Contents are not reset.
module data_memory_be #(
  parameter int DMEM_WORDS = 1024,
  parameter int AW         = $clog2(DMEM_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DMEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: memory stage of the RV32I pipeline plus the M->W register.
//   clk  in  clock
//   rst  in  asynchronous active-low reset; clears every W output and
//            blocks memory writes while low
//   bus  slave modport of memory_cycle_if (M-stage inputs, W-stage outputs)
// Performs byte/half/word loads and stores against data_memory_be, flags
// misaligned accesses, and registers everything writeback consumes.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter  int DMEM_WORDS = 1024,
  localparam int AW         = $clog2(DMEM_WORDS)
) (
  input  logic         clk,
  input  logic         rst,
  memory_cycle_if.slave bus
);

  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          is_load;
  logic          is_store;
  logic          legal_load;
  logic          legal_store;
  logic          addr_misalign;
  logic          load_misalign;
  logic          store_misalign;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rdata_word;
  mw_reg_t       mw_d;
  mw_reg_t       mw_q;

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign lane     = bus.ALU_ResultM[1:0];
  assign word_idx = bus.ALU_ResultM[AW+1:2];

  assign is_load  = (bus.ResultSrcM == RS_MEM);
  assign is_store = bus.MemWriteM;

  assign legal_store = (bus.funct3M == F3_B) || (bus.funct3M == F3_H) ||
                       (bus.funct3M == F3_W);
  assign legal_load  = legal_store || (bus.funct3M == F3_BU) ||
                       (bus.funct3M == F3_HU);

  // funct3[1:0] gives the size for every legal encoding; illegal encodings
  // are masked by the legality terms below.
  assign addr_misalign = ((bus.funct3M[1:0] == 2'b01) && lane[0]) ||
                         ((bus.funct3M[1:0] == 2'b10) && (lane != 2'b00));

  assign load_misalign  = is_load  && legal_load  && addr_misalign;
  assign store_misalign = is_store && legal_store && addr_misalign;

  always_comb begin
    be    = 4'b0000;
    wdata = {4{bus.WriteDataM[7:0]}};
    case (bus.funct3M)
      F3_H:    wdata = {2{bus.WriteDataM[15:0]}};
      F3_W:    wdata = bus.WriteDataM;
      default: wdata = {4{bus.WriteDataM[7:0]}};
    endcase
    // rst gates the enables so an edge seen while in reset drops the write.
    if (is_store && legal_store && !store_misalign && rst) begin
      case (bus.funct3M)
        F3_B:    be = 4'b0001 << lane;
        F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
        F3_W:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  data_memory_be #(
    .DMEM_WORDS (DMEM_WORDS),
    .AW         (AW)
  ) u_dmem (
    .clk     (clk),
    .we_i    (be),
    .addr_i  (word_idx),
    .wdata_i (wdata),
    .rdata_o (rdata_word)
  );

  always_comb begin
    mw_d            = '0;
    mw_d.reg_write  = bus.RegWriteM && !load_misalign;
    mw_d.result_src = bus.ResultSrcM;
    mw_d.rd         = bus.RD_M;
    mw_d.alu_result = bus.ALU_ResultM;
    mw_d.pc_plus4   = bus.PCPlus4M;
    mw_d.read_data  = load_misalign ? 32'h0
                                    : extend_load(bus.funct3M, rdata_word, lane);
    mw_d.misalign   = load_misalign || store_misalign;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mw_q <= '0;
    else      mw_q <= mw_d;
  end

  assign bus.RegWriteW   = mw_q.reg_write;
  assign bus.ResultSrcW  = mw_q.result_src;
  assign bus.RD_W        = mw_q.rd;
  assign bus.ALU_ResultW = mw_q.alu_result;
  assign bus.PCPlus4W    = mw_q.pc_plus4;
  assign bus.ReadDataW   = mw_q.read_data;
  assign bus.MisalignW   = mw_q.misalign;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: each driven M-stage op pushes its
// expected W-stage record, which is popped and compared after the next edge.
module tb_memory_cycle;

  logic clk = 1'b0;
  logic rst = 1'b0;

  memory_cycle_if bus ();

  memory_cycle #(.DMEM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        rdata_chk;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mdl[int];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rw"},  {31'h0, bus.RegWriteW},  32'h0);
    check({tag, "_rs"},  {30'h0, bus.ResultSrcW}, 32'h0);
    check({tag, "_rd"},  {27'h0, bus.RD_W},       32'h0);
    check({tag, "_alu"}, bus.ALU_ResultW,         32'h0);
    check({tag, "_pc4"}, bus.PCPlus4W,            32'h0);
    check({tag, "_rdt"}, bus.ReadDataW,           32'h0);
    check({tag, "_mis"}, {31'h0, bus.MisalignW},  32'h0);
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc4);
    bus.RegWriteM   = rw;
    bus.MemWriteM   = mw;
    bus.ResultSrcM  = rs;
    bus.funct3M     = f3;
    bus.RD_M        = rd;
    bus.ALU_ResultM = addr;
    bus.WriteDataM  = wd;
    bus.PCPlus4M    = pc4;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_rw"},  {31'h0, bus.RegWriteW},  {31'h0, e.rw});
    check({tag, "_rs"},  {30'h0, bus.ResultSrcW}, {30'h0, e.rs});
    check({tag, "_rd"},  {27'h0, bus.RD_W},       {27'h0, e.rd});
    check({tag, "_alu"}, bus.ALU_ResultW,         e.alu);
    check({tag, "_pc4"}, bus.PCPlus4W,            e.pc4);
    check({tag, "_mis"}, {31'h0, bus.MisalignW},  {31'h0, e.mis});
    if (e.rdata_chk) check({tag, "_rdata"}, bus.ReadDataW, e.rdata);
  endtask

  // One M-stage op: drive at negedge, model it, compare after the edge.
  task automatic do_op(input string tag, input logic rw, input logic mw,
                       input logic [1:0] rs, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t        e;
    int          ba;
    int          sz;
    logic        st_legal;
    logic        is_ld;
    logic        mis;
    logic [31:0] v;
    logic [31:0] pc4;
    pc4 = $urandom;
    @(negedge clk);
    drive(rw, mw, rs, f3, rd, addr, wd, pc4);
    ba = int'(addr & 32'hFFF);
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    st_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    is_ld    = (rs == 2'b01);
    mis      = ((sz == 2) && addr[0]) || ((sz == 4) && (addr[1:0] != 2'b00));
    e.rw        = rw && !(is_ld && (sz != 0) && mis);
    e.rs        = rs;
    e.rd        = rd;
    e.alu       = addr;
    e.pc4       = pc4;
    e.mis       = (is_ld && (sz != 0) && mis) || (mw && st_legal && mis);
    e.rdata_chk = is_ld;
    e.rdata     = 32'h0;
    if (is_ld && (sz != 0) && !mis) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) begin
        if (mdl.exists(ba + i)) v = v | (32'(mdl[ba + i]) << (8 * i));
        else                    e.rdata_chk = 1'b0;
      end
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
    end
    sb_q.push_back(e);
    if (mw && st_legal && !mis) begin
      for (int i = 0; i < sz; i++) mdl[ba + i] = wd[8*i +: 8];
    end
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  initial begin
    bus.RegWriteM = 0; bus.MemWriteM = 0; bus.ResultSrcM = 0; bus.funct3M = 0;
    bus.RD_M = 0; bus.ALU_ResultM = 0; bus.WriteDataM = 0; bus.PCPlus4M = 0;

    // Reset held with random inputs, including stores.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            5'($urandom), $urandom, $urandom, $urandom);
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;

    do_op("first",   1, 0, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0);
    do_op("sw10",    0, 1, 2'b00, 3'b010, 5'd0, 32'h10, 32'hDEAD_BEEF);
    do_op("lw10",    1, 0, 2'b01, 3'b010, 5'd7, 32'h10, 32'h0);

    do_op("sw20",    0, 1, 2'b00, 3'b010, 5'd0, 32'h20, 32'h0);
    do_op("sb23",    0, 1, 2'b00, 3'b000, 5'd0, 32'h23, 32'h80);
    do_op("sh20",    0, 1, 2'b00, 3'b001, 5'd0, 32'h20, 32'hBEEF);
    do_op("lw20",    1, 0, 2'b01, 3'b010, 5'd1, 32'h20, 32'h0);
    do_op("lb23",    1, 0, 2'b01, 3'b000, 5'd2, 32'h23, 32'h0);
    do_op("lbu23",   1, 0, 2'b01, 3'b100, 5'd3, 32'h23, 32'h0);
    do_op("lh20",    1, 0, 2'b01, 3'b001, 5'd4, 32'h20, 32'h0);
    do_op("lhu20",   1, 0, 2'b01, 3'b101, 5'd6, 32'h20, 32'h0);
    do_op("sh22",    0, 1, 2'b00, 3'b001, 5'd0, 32'h22, 32'h1357);
    do_op("lhu22",   1, 0, 2'b01, 3'b101, 5'd8, 32'h22, 32'h0);
    do_op("lb21",    1, 0, 2'b01, 3'b000, 5'd9, 32'h21, 32'h0);

    do_op("sw30",    0, 1, 2'b00, 3'b010, 5'd0, 32'h30, 32'h1234_5678);
    do_op("sw31mis", 0, 1, 2'b00, 3'b010, 5'd0, 32'h31, 32'hFFFF_FFFF);
    do_op("sh33mis", 0, 1, 2'b00, 3'b001, 5'd0, 32'h33, 32'hFFFF_FFFF);
    do_op("sx30ill", 0, 1, 2'b00, 3'b011, 5'd0, 32'h30, 32'hFFFF_FFFF);
    do_op("lw30",    1, 0, 2'b01, 3'b010, 5'd10, 32'h30, 32'h0);
    do_op("lh21mis", 1, 0, 2'b01, 3'b001, 5'd11, 32'h21, 32'h0);
    do_op("lw22mis", 1, 0, 2'b01, 3'b010, 5'd12, 32'h22, 32'h0);
    do_op("lill30",  1, 0, 2'b01, 3'b110, 5'd13, 32'h30, 32'h0);
    do_op("pc4op",   1, 0, 2'b10, 3'b001, 5'd14, 32'h21, 32'h0);

    do_op("sw1000",  0, 1, 2'b00, 3'b010, 5'd0, 32'h1000, 32'h55);
    do_op("lw0",     1, 0, 2'b01, 3'b010, 5'd15, 32'h0, 32'h0);

    // Reset asserted across a store edge: write dropped, outputs cleared.
    do_op("sw40",    0, 1, 2'b00, 3'b010, 5'd0, 32'h40, 32'h1111);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 3'b010, 5'd3, 32'h40, 32'hAAAA, 32'h44);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    do_op("lw40",    1, 0, 2'b01, 3'b010, 5'd16, 32'h40, 32'h0);

    // Random mix over a small window.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [2:0]  f;
      logic        st;
      a  = 32'h100 + 32'($urandom_range(0, 15));
      f  = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 1) == 1);
      if (st) do_op("rnd_st", 0, 1, 2'b00, f, 5'($urandom), a, $urandom);
      else    do_op("rnd_ld", 1'($urandom), 0, 2'($urandom_range(0, 2)), f,
                    5'($urandom), a, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the five-stage RV32I pipeline: performs RV32I loads and stores (byte, halfword, word, signed and unsigned) against a byte-enabled data memory. It registers everything the writeback stage consumes into the M→W pipeline register: RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW and ReadDataW. It sits between the execute stage and the writeback result mux, and is the producer of every W-stage input.

## Interface
Parameters:
- DMEM_WORDS, 1024: data memory depth in 32-bit words; must be a power of two.
- AW, $clog2(DMEM_WORDS): word-index width, derived and not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteM  in  1  instruction writes rd.
- MemWriteM  in  1  instruction is a store.
- ResultSrcM  in  2  result select: 00 ALU, 01 memory, 10 PC+4; 11 is reserved.
- funct3M  in  3  access size and sign for loads and stores.
- RD_M  in  5  destination register.
- ALU_ResultM  in  32  effective address; also the ALU result.
- WriteDataM  in  32  store data, right-aligned.
- PCPlus4M  in  32  PC+4 of the instruction.
- RegWriteW  out  1  registered RegWriteM, forced to 0 on a misaligned load.
- ResultSrcW  out  2  registered ResultSrcM.
- RD_W  out  5  registered RD_M.
- ALU_ResultW  out  32  registered ALU_ResultM.
- PCPlus4W  out  32  registered PCPlus4M.
- ReadDataW  out  32  registered, extended load data.
- MisalignW  out  1  registered misaligned-access flag.

## Operation
- A load is any cycle with ResultSrcM == 01. A store is any cycle with MemWriteM == 1. Both must never be asserted together; if they are, the store takes effect and the load data is still captured.
- The word index is ALU_ResultM[AW+1:2]. Higher address bits are ignored, so addresses wrap modulo 4·DMEM_WORDS bytes.
- Lane selection uses ALU_ResultM[1:0].
- Stores:
  - SB (000): byte lane = addr[1:0].
  - SH (001): lanes {addr[1],0} and {addr[1],1}.
  - SW (010): all four lanes.
  - Data is replicated into the selected lanes.
- Loads:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) returns the full word.
- Any other funct3 on a load or store is illegal: the store is suppressed and ReadDataW is 0.
- Misaligned access:
  - Halfword with addr[0] = 1, or word with addr[1:0] != 00.
  - A misaligned store is suppressed: no lane is written.
  - A misaligned load sets ReadDataW = 0 and clears RegWriteW.
  - In both cases MisalignW = 1.
- On non-memory instructions, ReadDataW carries the extended read data anyway; the writeback mux ignores it. MisalignW = 0.
- Data memory contents are not reset and are undefined until written.

## Timing
- The memory read is combinational from ALU_ResultM within the M cycle. All W outputs update at the next rising edge: M→W latency is exactly 1 cycle.
- A store commits to memory at the rising edge ending its M cycle. A load in the immediately following M cycle at the same address returns the new data; no bypass is needed.
- While rst = 0, the following outputs are 0 immediately, independent of clk: RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, ReadDataW, MisalignW.
- While rst = 0, memory writes are blocked.
- Reset asserted mid-store: the write is dropped if rst is low at the edge.
- After rst deasserts, the first edge captures the M inputs normally.
- The block has no stall or flush. Bubbles arrive as RegWriteM = 0 and MemWriteM = 0 from upstream.

## Structure
- Shared package riscv_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - ResultSrc encodings RS_ALU, RS_MEM, RS_PC4.
- Sub-module data_memory_be:
  - DMEM_WORDS × 32-bit array, 4-bit byte-enable synchronous write, asynchronous read.
  - It has no reset.
- memory_cycle contains:
  - Lane/byte-enable generation.
  - Load extraction and extension.
  - Misalignment detection.
  - The M→W register.

## Test plan
- Reset: hold rst = 0 with random M inputs → all W outputs read 0; deassert, drive RegWriteM = 1, RD_M = 5, ALU_ResultM = 0x1234 → next edge: RD_W = 5, ALU_ResultW = 0x1234.
- SW then LW: SW 0xDEADBEEF at 0x10, then LW 0x10 next cycle → ReadDataW = 0xDEADBEEF one cycle after the load.
- Sub-word stores and loads:
  - Setup: word 0x20 = 0, then SB 0x80 at 0x23 and SH 0xBEEF at 0x20.
  - LW 0x20 → 0x8000BEEF.
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LH 0x20 → 0xFFFFBEEF; LHU 0x20 → 0x0000BEEF.
- Misalignment:
  - SW at 0x31 → word 0x30 unchanged, MisalignW = 1.
  - LH at 0x21 with RegWriteM = 1 → RegWriteW = 0, ReadDataW = 0, MisalignW = 1.
- Wrap: with DMEM_WORDS = 1024, SW 0x55 at 0x1000, then LW 0x0 → 0x55.
- Reset mid-store: SW 0xAAAA at 0x40 with rst pulled low across the edge → subsequent LW 0x40 returns the prior value.
